// File: rtl/coef_pkg.sv
// coef_pkg: shared coefficient defaults (width, depth, reset table) and FSM state encodings
package coef_pkg;

    localparam int CANT_BITS_DEF = 25;
    localparam int N_COEF_DEF    = 16;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

    // Default table as signed 32-bit values; callers sign-extend or truncate to their width.
    // Entry 2 is 0x1FFC287 in 25-bit two's complement, i.e. a negative coefficient.
    function automatic logic signed [31:0] def_coef(input int i);
        return (i == 0)           ? 32'sh0000_4000 :
               (i == 1)           ? 32'sh0000_7D71 :
               (i == 2)           ? 32'shFFFF_C287 :
               (i == 5 || i == 7) ? 32'sh0000_0003 :
               (i == 6)           ? 32'sh0000_0007 : 32'sh0000_0000;
    endfunction

endpackage

// File: rtl/coef_regfile.sv
// coef_regfile: N x W register array with single write port, bulk-load port, reset to the default table
// Ports: clk, reset_n (async active-low), we/waddr/wdata (single-entry write),
//        load/load_data (whole-array copy, wins over write), rd (all entries, flat view)
module coef_regfile
    import coef_pkg::*;
#(
    parameter int W  = CANT_BITS_DEF,
    parameter int N  = N_COEF_DEF,
    parameter int AW = $clog2(N)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [W-1:0]        wdata,
    input  logic                load,
    input  logic [N-1:0][W-1:0] load_data,
    output logic [N-1:0][W-1:0] rd
);

    logic [N-1:0][W-1:0] mem_q, mem_d;

    always_comb begin
        mem_d = mem_q;
        for (int i = 0; i < N; i++)
            mem_d[i] = load ? load_data[i] : (we && waddr == AW'(i)) ? wdata : mem_q[i];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++)
                mem_q[i] <= W'(def_coef(i));
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd = mem_q;

endmodule

// File: rtl/coef_bank.sv
// coef_bank: coefficient store with optional shadow bank swapped into the active bank on a frame boundary
// Ports: clk, reset_n (async active-low); sel_cte -> cte (registered read, latency 1, 0 when out of range);
//        wr_en/wr_addr/wr_data (write, wr_err pulses on bad address); commit/frame_start (swap request/boundary);
//        pending (commit waiting), commit_done (pulse after swap).
// Macro COEF_SHADOW_EN: defined -> double-buffered shadow/active; undefined -> writes go straight to active.
module coef_bank
    import coef_pkg::*;
#(
    parameter int CANT_BITS = CANT_BITS_DEF,
    parameter int N_COEF    = N_COEF_DEF,
    parameter int SEL_W     = $clog2(N_COEF)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [SEL_W-1:0]     sel_cte,
    output logic [CANT_BITS-1:0] cte,
    input  logic                 wr_en,
    input  logic [SEL_W-1:0]     wr_addr,
    input  logic [CANT_BITS-1:0] wr_data,
    input  logic                 commit,
    input  logic                 frame_start,
    output logic                 pending,
    output logic                 commit_done,
    output logic                 wr_err
);

    localparam logic [SEL_W:0] LIMIT = (SEL_W + 1)'(N_COEF);

    logic [N_COEF-1:0][CANT_BITS-1:0] act;
    logic                             wr_ok;
    logic                             wr_err_d, wr_err_q;
    logic                             commit_done_d, commit_done_q;
    logic [CANT_BITS-1:0]             cte_d, cte_q;

    assign wr_ok    = wr_en && ({1'b0, wr_addr} < LIMIT);
    assign wr_err_d = wr_en && !wr_ok;

    // Out-of-range selects match no entry and fall through to zero.
    always_comb begin
        cte_d = '0;
        for (int i = 0; i < N_COEF; i++)
            cte_d = (sel_cte == SEL_W'(i)) ? act[i] : cte_d;
    end

`ifdef COEF_SHADOW_EN
    logic [N_COEF-1:0][CANT_BITS-1:0] shd;
    logic [0:0]                       state_q, state_d;
    logic                             swap;

    assign swap          = (state_q == ST_PEND) && frame_start;
    // A commit while pending is ignored; a frame_start in the commit cycle itself does not swap.
    assign state_d       = (state_q == ST_IDLE) ? (commit ? ST_PEND : ST_IDLE) : (frame_start ? ST_IDLE : ST_PEND);
    assign commit_done_d = swap;
    assign pending       = (state_q == ST_PEND);

    // A write landing on the swap edge reaches shadow only; active copies the pre-edge shadow.
    coef_regfile #(.W(CANT_BITS), .N(N_COEF), .AW(SEL_W)) u_shadow (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (wr_ok),
        .waddr     (wr_addr),
        .wdata     (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .rd        (shd)
    );

    coef_regfile #(.W(CANT_BITS), .N(N_COEF), .AW(SEL_W)) u_active (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (1'b0),
        .waddr     ('0),
        .wdata     ('0),
        .load      (swap),
        .load_data (shd),
        .rd        (act)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end
`else
    logic unused_frame_start;

    assign unused_frame_start = frame_start;
    assign commit_done_d      = commit;
    assign pending            = 1'b0;

    coef_regfile #(.W(CANT_BITS), .N(N_COEF), .AW(SEL_W)) u_active (
        .clk       (clk),
        .reset_n   (reset_n),
        .we        (wr_ok),
        .waddr     (wr_addr),
        .wdata     (wr_data),
        .load      (1'b0),
        .load_data ('0),
        .rd        (act)
    );
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cte_q         <= '0;
            commit_done_q <= 1'b0;
            wr_err_q      <= 1'b0;
        end else begin
            cte_q         <= cte_d;
            commit_done_q <= commit_done_d;
            wr_err_q      <= wr_err_d;
        end
    end

    assign cte         = cte_q;
    assign commit_done = commit_done_q;
    assign wr_err      = wr_err_q;

endmodule
